frame_mem_arbiter: RTL and testbench
====================================

Name: frame_mem_arbiter

Overview:
- Schedules one single-port frame memory between two requesters: the input-stream writer and the display read pipeline.
- The display pipeline is driven by the display sync generator.
- Implements double buffering: two frame banks, swapped only on a display vsync rising edge after the writer has completed a frame.
- Display reads have absolute priority. Writes use idle slots. Writer starvation is flagged.

Parameters:
- AW, 12, per-bank word address width; memory address is AW+1 bits, MSB = bank.
- DW, 24, data width (one pixel per word).
- MEM_LAT, 1, memory read latency in cycles from registered command to i_mem_rdata valid; legal range 1..4.
- STARVE_MAX, 64, consecutive cycles of a pending, un-acked write before starvation is flagged; must be ≥ 1.

Ports:
- i_clk  in  1  clock
- rst_n  in  1  async active-low reset
- i_vsync  in  1  display vsync level, synchronous to i_clk
- i_rd_req  in  1  display read request
- i_rd_addr  in  AW  display read word address
- o_rd_ack  out  1  read accepted this cycle
- o_rd_valid  out  1  o_rd_data valid
- o_rd_data  out  DW  read data
- i_wr_req  in  1  write request
- i_wr_addr  in  AW  write word address
- i_wr_data  in  DW  write data
- o_wr_ack  out  1  write accepted this cycle
- i_wr_frame_done  in  1  one-cycle pulse: last word of frame has been acked
- i_err_clr  in  1  clears o_wr_starve
- o_mem_en  out  1  memory command valid
- o_mem_we  out  1  1 = write command
- o_mem_addr  out  AW+1  {bank, word address}
- o_mem_wdata  out  DW  write data
- i_mem_rdata  in  DW  memory read data
- o_frame_valid  out  1  a completed frame is being displayed
- o_rd_bank  out  1  bank currently being displayed
- o_repeat_cnt  out  8  saturating count of vsyncs with no new frame while in SHOW

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is i_clk.
- Reset values:
  - All outputs 0 except wr_bank internal = 1.
  - rd_bank = 0; FSM = S_INIT.
  - Read-valid pipeline cleared; vsync edge register = 0; starve counter = 0.
- Grant (combinational):
  - o_rd_ack = i_rd_req.
  - o_wr_ack = i_wr_req & ~i_rd_req & (state != S_PEND).
  - At most one grant per cycle.
- Memory command is registered, 1 cycle after the grant:
  - o_mem_en = rd_ack | wr_ack.
  - o_mem_we = wr_ack.
  - o_mem_addr = read ? {rd_bank, i_rd_addr} : {wr_bank, i_wr_addr}, using bank values as of the grant cycle.
  - o_mem_wdata = i_wr_data on write; held otherwise.
- Read return:
  - o_rd_valid is a shift register of o_rd_ack, delay 1+MEM_LAT.
  - o_rd_data = i_mem_rdata (pass-through), meaningful only when o_rd_valid = 1.
  - Latency from ack at cycle T to valid at T+1+MEM_LAT. Back-to-back reads give back-to-back valids.
- Vsync edge: vs_rise = i_vsync & ~vsync_q, where vsync_q is registered.
- Bank FSM:
  - S_INIT: no complete frame yet; o_frame_valid = 0. i_wr_frame_done → S_PEND. vs_rise → stay, no count.
  - S_PEND: wr_bank holds a complete frame; writes are blocked (o_wr_ack = 0). vs_rise → swap rd_bank/wr_bank, → S_SHOW, o_frame_valid ← 1. i_wr_frame_done here is ignored.
  - S_SHOW: i_wr_frame_done → S_PEND. vs_rise without frame_done in the same cycle → o_repeat_cnt += 1, saturating at 255.
- Simultaneous i_wr_frame_done and vs_rise:
  - Done wins: move to S_PEND, no swap this vsync, no repeat increment.
  - The swap occurs on the next vs_rise.
- A swap takes effect on the cycle after vs_rise. Reads granted in the vs_rise cycle use the old bank.
- o_repeat_cnt resets to 0 on every swap.
- Starvation:
  - Counter increments each cycle i_wr_req & ~o_wr_ack, including while in S_PEND.
  - Clears on o_wr_ack or when i_wr_req is low.
  - On reaching STARVE_MAX, o_wr_starve sets and is sticky.
  - i_err_clr clears the flag and the counter; if set and clear coincide, set wins.
- Counter widths: starve counter is $clog2(STARVE_MAX+1) bits and saturates.
- Reset mid-operation: in-flight read valids are discarded; the FSM returns to S_INIT.

Test Plan:
- Reset, then idle 10 cycles → all outputs 0, o_rd_bank = 0, o_frame_valid = 0; one cycle after a write is accepted, o_mem_addr MSB = 1 (wr_bank = 1).
- MEM_LAT = 2: read at addr 0x005 acked at T, memory model returns 0xABCDEF → o_mem_addr = 0x005 at T+1; o_rd_valid = 1 with data 0xABCDEF at T+3 only.
- i_rd_req and i_wr_req held together for 70 cycles with STARVE_MAX = 64:
  - o_wr_ack stays 0.
  - o_wr_starve rises after 64 pending cycles and stays high until i_err_clr.
  - After rd_req drops, the write is acked and the next o_mem_we = 1.
- Write frame, pulse i_wr_frame_done, then vs_rise:
  - FSM goes S_PEND → S_SHOW.
  - o_rd_bank = 1, o_frame_valid = 1.
  - Writes blocked (o_wr_ack = 0) between done and vsync.
  - Subsequent write commands use bank 0.
- In S_SHOW, 3 vsyncs with no frame_done → o_repeat_cnt = 3; next frame_done plus vsync → swap, o_repeat_cnt = 0, o_rd_bank = 0.
- frame_done and vs_rise in the same cycle in S_SHOW → no swap and o_repeat_cnt unchanged; swap on the following vs_rise. Assert rst_n low with a read in flight → o_rd_valid never asserts for it.

Source files
------------

// File: rtl/frame_mem_arbiter.sv
// Frame memory arbiter: double-buffered single-port memory shared by display reads and stream writes.
// Latency: memory command registered 1 cycle after grant; read data valid 1+MEM_LAT cycles after o_rd_ack.
// Backpressure: reads always granted; writes take idle slots, are held off while a finished frame awaits vsync.
module frame_mem_arbiter #(
  parameter int AW         = 12,
  parameter int DW         = 24,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 64
) (
  input  logic          i_clk,
  input  logic          rst_n,
  input  logic          i_vsync,
  input  logic          i_rd_req,
  input  logic [AW-1:0] i_rd_addr,
  output logic          o_rd_ack,
  output logic          o_rd_valid,
  output logic [DW-1:0] o_rd_data,
  input  logic          i_wr_req,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  output logic          o_wr_ack,
  input  logic          i_wr_frame_done,
  input  logic          i_err_clr,
  output logic          o_wr_starve,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW:0]   o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_frame_valid,
  output logic          o_rd_bank,
  output logic [7:0]    o_repeat_cnt
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [SW-1:0] STARVE_HIT = SW'(STARVE_MAX - 1);

  typedef enum logic [1:0] {S_INIT, S_PEND, S_SHOW} state_t;

  state_t          state_q, state_d;
  logic            vsync_q, vsync_d;
  logic            rd_bank_q, rd_bank_d;
  logic            frame_valid_q, frame_valid_d;
  logic [7:0]      repeat_cnt_q, repeat_cnt_d;
  logic [MEM_LAT:0] rd_vld_q, rd_vld_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [AW:0]     mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
  logic            starve_q, starve_d;

  logic vs_rise;
  logic wr_bank;
  logic rd_ack, wr_ack;
  logic swap, rpt_inc, wr_block;
  logic wr_pend, starve_hit;

  // The write bank is always the one not on display, so it is 1 out of reset.
  assign wr_bank = ~rd_bank_q;

  // Rising edge of the display vsync level.
  always_comb begin
    vsync_d = i_vsync;
    vs_rise = i_vsync & ~vsync_q;
  end

  // Grants: display reads always win; writes only in idle slots and never while a frame waits for swap.
  always_comb begin
    rd_ack = i_rd_req;
    wr_ack = i_wr_req & ~i_rd_req & ~wr_block;
  end

  // Bank FSM next state: frame_done beats a coincident vsync, deferring the swap to the next vsync.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  if (i_wr_frame_done) state_d = S_PEND;
      S_PEND:  if (vs_rise)         state_d = S_SHOW;
      S_SHOW:  if (i_wr_frame_done) state_d = S_PEND;
      default: state_d = S_INIT;
    endcase
  end

  // Bank FSM outputs: swap strobe, repeat strobe and write hold-off.
  always_comb begin
    swap     = 1'b0;
    rpt_inc  = 1'b0;
    wr_block = 1'b0;
    case (state_q)
      S_PEND: begin
        wr_block = 1'b1;
        swap     = vs_rise;
      end
      S_SHOW:  rpt_inc = vs_rise & ~i_wr_frame_done;
      default: ;
    endcase
  end

  // Display bank, frame-valid and repeat counter updates driven by the FSM strobes.
  always_comb begin
    rd_bank_d     = rd_bank_q;
    frame_valid_d = frame_valid_q;
    repeat_cnt_d  = repeat_cnt_q;
    if (swap) begin
      rd_bank_d     = ~rd_bank_q;
      frame_valid_d = 1'b1;
      repeat_cnt_d  = 8'd0;
    end else if (rpt_inc && (repeat_cnt_q != 8'hFF)) begin
      repeat_cnt_d  = repeat_cnt_q + 8'd1;
    end
  end

  // Memory command built from the grant, using the bank as it stands in the grant cycle.
  always_comb begin
    mem_en_d    = rd_ack | wr_ack;
    mem_we_d    = wr_ack;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (rd_ack) begin
      mem_addr_d  = {rd_bank_q, i_rd_addr};
    end else if (wr_ack) begin
      mem_addr_d  = {wr_bank, i_wr_addr};
      mem_wdata_d = i_wr_data;
    end
  end

  // Read-valid shift register tracks accepted reads through command register plus memory latency.
  always_comb begin
    rd_vld_d = {rd_vld_q[MEM_LAT-1:0], rd_ack};
  end

  // Starvation: count consecutive pending cycles; flag fires once on reaching the limit and is sticky.
  always_comb begin
    wr_pend    = i_wr_req & ~wr_ack;
    starve_hit = wr_pend & (starve_cnt_q == STARVE_HIT);
    if (i_err_clr || !wr_pend) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q == STARVE_TOP) begin
      starve_cnt_d = starve_cnt_q;
    end else begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
    starve_d = starve_hit | (starve_q & ~i_err_clr);
  end

  // State registers.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_INIT;
      vsync_q       <= 1'b0;
      rd_bank_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      repeat_cnt_q  <= 8'd0;
      rd_vld_q      <= '0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      starve_cnt_q  <= '0;
      starve_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      vsync_q       <= vsync_d;
      rd_bank_q     <= rd_bank_d;
      frame_valid_q <= frame_valid_d;
      repeat_cnt_q  <= repeat_cnt_d;
      rd_vld_q      <= rd_vld_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      starve_cnt_q  <= starve_cnt_d;
      starve_q      <= starve_d;
    end
  end

  assign o_rd_ack      = rd_ack;
  assign o_wr_ack      = wr_ack;
  assign o_rd_valid    = rd_vld_q[MEM_LAT];
  assign o_rd_data     = i_mem_rdata;
  assign o_wr_starve   = starve_q;
  assign o_mem_en      = mem_en_q;
  assign o_mem_we      = mem_we_q;
  assign o_mem_addr    = mem_addr_q;
  assign o_mem_wdata   = mem_wdata_q;
  assign o_frame_valid = frame_valid_q;
  assign o_rd_bank     = rd_bank_q;
  assign o_repeat_cnt  = repeat_cnt_q;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Bench for frame_mem_arbiter: directed stimulus, expected commands/read data queued, monitor compares.
// Latency: checks command at grant+1 and read data at grant+1+MEM_LAT exactly.
// Backpressure: write hold-off and starvation flag checked cycle by cycle.
module tb_frame_mem_arbiter;

  localparam int AW = 12;
  localparam int DW = 24;
  localparam int MEM_LAT = 2;
  localparam int STARVE_MAX = 64;

  logic          i_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_vsync = 1'b0;
  logic          i_rd_req = 1'b0;
  logic [AW-1:0] i_rd_addr = '0;
  logic          o_rd_ack;
  logic          o_rd_valid;
  logic [DW-1:0] o_rd_data;
  logic          i_wr_req = 1'b0;
  logic [AW-1:0] i_wr_addr = '0;
  logic [DW-1:0] i_wr_data = '0;
  logic          o_wr_ack;
  logic          i_wr_frame_done = 1'b0;
  logic          i_err_clr = 1'b0;
  logic          o_wr_starve;
  logic          o_mem_en;
  logic          o_mem_we;
  logic [AW:0]   o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [DW-1:0] i_mem_rdata;
  logic          o_frame_valid;
  logic          o_rd_bank;
  logic [7:0]    o_repeat_cnt;

  frame_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .i_clk(i_clk), .rst_n(rst_n), .i_vsync(i_vsync),
    .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .o_rd_ack(o_rd_ack),
    .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
    .i_wr_req(i_wr_req), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .o_wr_ack(o_wr_ack),
    .i_wr_frame_done(i_wr_frame_done), .i_err_clr(i_err_clr), .o_wr_starve(o_wr_starve),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
    .o_frame_valid(o_frame_valid), .o_rd_bank(o_rd_bank), .o_repeat_cnt(o_repeat_cnt)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic we; logic [AW:0] addr; logic [DW-1:0] wdata; } cmd_t;
  typedef struct { int cyc; logic [DW-1:0] data; } rdv_t;
  cmd_t cmd_q[$];
  rdv_t rdv_q[$];

  // Memory model: unwritten words hold a recognisable pattern; address 0x005 preloaded with 0xABCDEF.
  logic [DW-1:0] mem [0:(1<<(AW+1))-1];
  logic          written [0:(1<<(AW+1))-1];
  logic [DW-1:0] rpipe [MEM_LAT];

  function automatic logic [DW-1:0] preload(input logic [AW:0] a);
    if (a == 13'h0005) return 24'hABCDEF;
    return {8'h5A, 3'b000, a};
  endfunction

  always @(posedge i_clk) begin
    if (o_mem_en && o_mem_we) begin
      mem[o_mem_addr]     <= o_mem_wdata;
      written[o_mem_addr] <= 1'b1;
    end
    rpipe[0] <= (written[o_mem_addr] === 1'b1) ? mem[o_mem_addr] : preload(o_mem_addr);
    for (int i = 1; i < MEM_LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign i_mem_rdata = rpipe[MEM_LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every command and every read return must match the head of its queue.
  always @(negedge i_clk) begin
    cmd_t c;
    rdv_t r;
    if (o_mem_en) begin
      if (cmd_q.size() == 0) chk("unexpected_cmd", {19'd0, o_mem_addr}, 32'hFFFFFFFF);
      else begin
        c = cmd_q.pop_front();
        chk("cmd_cycle", cyc, c.cyc);
        chk("cmd_we", {31'd0, o_mem_we}, {31'd0, c.we});
        chk("cmd_addr", {19'd0, o_mem_addr}, {19'd0, c.addr});
        if (c.we) chk("cmd_wdata", {8'd0, o_mem_wdata}, {8'd0, c.wdata});
      end
    end
    if (o_rd_valid) begin
      if (rdv_q.size() == 0) chk("unexpected_rd_valid", {8'd0, o_rd_data}, 32'hFFFFFFFF);
      else begin
        r = rdv_q.pop_front();
        chk("rd_valid_cycle", cyc, r.cyc);
        chk("rd_data", {8'd0, o_rd_data}, {8'd0, r.data});
      end
    end
  end

  // One clock of stimulus: inputs already set by caller; checks grants and queues expected responses.
  task automatic tick(input logic e_rd, input logic e_wr, input logic bank, input logic [DW-1:0] rdat);
    cmd_t c;
    rdv_t r;
    @(negedge i_clk);
    chk("rd_ack", {31'd0, o_rd_ack}, {31'd0, e_rd});
    chk("wr_ack", {31'd0, o_wr_ack}, {31'd0, e_wr});
    if (e_rd) begin
      c.cyc = cyc + 1; c.we = 1'b0; c.addr = {bank, i_rd_addr}; c.wdata = '0;
      cmd_q.push_back(c);
      r.cyc = cyc + 1 + MEM_LAT; r.data = rdat;
      rdv_q.push_back(r);
    end else if (e_wr) begin
      c.cyc = cyc + 1; c.we = 1'b1; c.addr = {bank, i_wr_addr}; c.wdata = i_wr_data;
      cmd_q.push_back(c);
    end
    @(posedge i_clk);
    #1;
    i_rd_req = 1'b0; i_wr_req = 1'b0; i_vsync = 1'b0; i_wr_frame_done = 1'b0; i_err_clr = 1'b0;
  endtask

  task automatic vs_pulse();
    i_vsync = 1'b1;
    tick(1'b0, 1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic chk_state(input string tag, input logic bank, input logic fv, input logic [7:0] rpt);
    chk({tag, "_rd_bank"}, {31'd0, o_rd_bank}, {31'd0, bank});
    chk({tag, "_frame_valid"}, {31'd0, o_frame_valid}, {31'd0, fv});
    chk({tag, "_repeat_cnt"}, {24'd0, o_repeat_cnt}, {24'd0, rpt});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge i_clk);
    #1 rst_n = 1'b1;

    // Reset state after 10 idle cycles.
    repeat (10) tick(1'b0, 1'b0, 1'b0, '0);
    chk("rst_mem_en", {31'd0, o_mem_en}, 0);
    chk("rst_mem_we", {31'd0, o_mem_we}, 0);
    chk("rst_mem_addr", {19'd0, o_mem_addr}, 0);
    chk("rst_mem_wdata", {8'd0, o_mem_wdata}, 0);
    chk("rst_rd_valid", {31'd0, o_rd_valid}, 0);
    chk("rst_wr_starve", {31'd0, o_wr_starve}, 0);
    chk_state("rst", 1'b0, 1'b0, 8'd0);

    // First write goes to bank 1.
    i_wr_req = 1'b1; i_wr_addr = 12'h0AB; i_wr_data = 24'h123456;
    tick(1'b0, 1'b1, 1'b1, '0);

    // Read 0x005 from bank 0: command next cycle, data 0xABCDEF at ack+3.
    i_rd_req = 1'b1; i_rd_addr = 12'h005;
    tick(1'b1, 1'b0, 1'b0, 24'hABCDEF);
    repeat (4) tick(1'b0, 1'b0, 1'b0, '0);

    // Read and write held together for 70 cycles: write starves, flag after 64 pending cycles.
    for (int k = 0; k < 70; k++) begin
      i_rd_req = 1'b1; i_rd_addr = 12'h010;
      i_wr_req = 1'b1; i_wr_addr = 12'h020; i_wr_data = 24'h0000AA;
      tick(1'b1, 1'b0, 1'b0, 24'h5A0010);
      chk("starve_flag", {31'd0, o_wr_starve}, {31'd0, (k >= 63)});
    end
    i_wr_req = 1'b1; i_wr_addr = 12'h020; i_wr_data = 24'h0000AA;
    tick(1'b0, 1'b1, 1'b1, '0);
    chk("starve_sticky", {31'd0, o_wr_starve}, 1);
    tick(1'b0, 1'b0, 1'b0, '0);
    chk("starve_sticky_idle", {31'd0, o_wr_starve}, 1);
    i_err_clr = 1'b1;
    tick(1'b0, 1'b0, 1'b0, '0);
    chk("starve_cleared", {31'd0, o_wr_starve}, 0);
    repeat (3) tick(1'b0, 1'b0, 1'b0, '0);

    // Vsync before any complete frame changes nothing.
    vs_pulse();
    chk_state("init_vs", 1'b0, 1'b0, 8'd0);

    // Write a frame into bank 1, then frame_done: writes held until vsync.
    for (int i = 0; i < 4; i++) begin
      i_wr_req = 1'b1; i_wr_addr = 12'(i); i_wr_data = 24'h111100 + 24'(i);
      tick(1'b0, 1'b1, 1'b1, '0);
    end
    i_wr_frame_done = 1'b1;
    tick(1'b0, 1'b0, 1'b0, '0);
    i_wr_req = 1'b1; i_wr_addr = 12'h004; i_wr_data = 24'h999999;
    tick(1'b0, 1'b0, 1'b0, '0);
    chk_state("pend", 1'b0, 1'b0, 8'd0);
    // vsync rise with a read: read still uses old bank 0, write still held.
    i_vsync = 1'b1; i_rd_req = 1'b1; i_rd_addr = 12'h002;
    tick(1'b1, 1'b0, 1'b0, 24'h5A0002);
    chk_state("swap1", 1'b1, 1'b1, 8'd0);
    i_rd_req = 1'b1; i_rd_addr = 12'h002;
    tick(1'b1, 1'b0, 1'b1, 24'h111102);
    i_wr_req = 1'b1; i_wr_addr = 12'h007; i_wr_data = 24'h777777;
    tick(1'b0, 1'b1, 1'b0, '0);

    // Three vsyncs with no new frame.
    repeat (3) vs_pulse();
    chk_state("repeat3", 1'b1, 1'b1, 8'd3);
    i_wr_frame_done = 1'b1;
    tick(1'b0, 1'b0, 1'b0, '0);
    i_wr_req = 1'b1; i_wr_addr = 12'h008;
    tick(1'b0, 1'b0, 1'b0, '0);
    chk_state("pend2", 1'b1, 1'b1, 8'd3);
    vs_pulse();
    chk_state("swap2", 1'b0, 1'b1, 8'd0);
    i_rd_req = 1'b1; i_rd_addr = 12'h007;
    tick(1'b1, 1'b0, 1'b0, 24'h777777);

    // frame_done coinciding with vsync: no swap, no count; swap on the next vsync.
    vs_pulse();
    chk_state("repeat1", 1'b0, 1'b1, 8'd1);
    i_vsync = 1'b1; i_wr_frame_done = 1'b1;
    tick(1'b0, 1'b0, 1'b0, '0);
    chk_state("coincide", 1'b0, 1'b1, 8'd1);
    i_wr_req = 1'b1; i_wr_addr = 12'h009;
    tick(1'b0, 1'b0, 1'b0, '0);
    vs_pulse();
    chk_state("swap3", 1'b1, 1'b1, 8'd0);
    i_wr_req = 1'b1; i_wr_addr = 12'h00A; i_wr_data = 24'h0A0A0A;
    tick(1'b0, 1'b1, 1'b0, '0);
    repeat (4) tick(1'b0, 1'b0, 1'b0, '0);

    // Reset with a read in flight: its valid must never appear.
    i_rd_req = 1'b1; i_rd_addr = 12'h005;
    @(negedge i_clk);
    chk("rd_ack_before_reset", {31'd0, o_rd_ack}, 1);
    @(posedge i_clk);
    #1;
    i_rd_req = 1'b0;
    rst_n = 1'b0;
    repeat (5) @(posedge i_clk);
    #1 rst_n = 1'b1;
    repeat (6) tick(1'b0, 1'b0, 1'b0, '0);
    chk_state("post_rst", 1'b0, 1'b0, 8'd0);
    chk("post_rst_starve", {31'd0, o_wr_starve}, 0);
    i_wr_req = 1'b1; i_wr_addr = 12'h00B; i_wr_data = 24'h0B0B0B;
    tick(1'b0, 1'b1, 1'b1, '0);
    repeat (4) tick(1'b0, 1'b0, 1'b0, '0);

    chk("cmd_queue_drained", cmd_q.size(), 0);
    chk("rdv_queue_drained", rdv_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
